// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the LEGv8 fetch stage
package fetch_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;
  localparam int CNT_W       = 32;
  localparam int INSTR_BYTES = 4;
  localparam int BR_SHIFT    = 2;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_adder.sv
// rtl/next_pc_adder.sv - next-PC selection: sequential step or word-offset branch
module next_pc_adder
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] instr_pc,
  input  logic [PC_W-1:0] bus_imm,
  input  logic            branch_taken,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] offset;

  // BusImm counts words; the shift turns it into a byte offset, wrapping mod 2^64
  always_comb begin
    offset = PC_W'(INSTR_BYTES);
    if (branch_taken) begin
      offset = bus_imm << BR_SHIFT;
    end
    next_pc = instr_pc + offset;
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner issuing req/ack word reads and holding Instr for decode
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic                Clk,
  input  logic                Resetl,
  output logic [PC_W-1:0]     IMemAddr,
  output logic                IMemReq,
  input  logic                IMemAck,
  input  logic [INSTR_W-1:0]  IMemData,
  output logic [INSTR_W-1:0]  Instr,
  output logic [PC_W-1:0]     InstrPC,
  output logic                InstrValid,
  input  logic                DecodeReady,
  input  logic                BranchTaken,
  input  logic [PC_W-1:0]     BusImm,
  output logic [CNT_W-1:0]    InstrCount
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PC_W-1:0]     next_pc;

  next_pc_adder u_next_pc_adder (
    .instr_pc     (instr_pc_q),
    .bus_imm      (BusImm),
    .branch_taken (BranchTaken),
    .next_pc      (next_pc)
  );

  always_ff @(posedge Clk) begin
    if (!Resetl) begin
      state_q    <= ST_RESET;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  // req/valid are computed alongside the next state so both leave as flops
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        valid_d = 1'b0;
      end
      ST_FETCH: begin
        if (IMemAck) begin
          state_d    = ST_HOLD;
          req_d      = 1'b0;
          valid_d    = 1'b1;
          instr_d    = IMemData;
          instr_pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (DecodeReady) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          valid_d = 1'b0;
          pc_d    = next_pc;
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign IMemAddr   = pc_q;
  assign IMemReq    = req_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = valid_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        Clk = 1'b0;
  logic        Resetl;
  logic [63:0] IMemAddr;
  logic        IMemReq;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrValid;
  logic        DecodeReady;
  logic        BranchTaken;
  logic [63:0] BusImm;
  logic [31:0] InstrCount;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;

  logic [63:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [63:0] cur_pc;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .Clk         (Clk),
    .Resetl      (Resetl),
    .IMemAddr    (IMemAddr),
    .IMemReq     (IMemReq),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .DecodeReady (DecodeReady),
    .BranchTaken (BranchTaken),
    .BusImm      (BusImm),
    .InstrCount  (InstrCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, then checks its address against the scoreboard.
  task automatic wait_req(input string tag);
    logic [63:0] exp_a;
    for (int i = 0; i < 20; i++) begin
      if (IMemReq === 1'b1) break;
      @(negedge Clk);
    end
    chk({tag, "_req"}, {63'd0, IMemReq}, 64'd1);
    exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : 64'hDEAD;
    chk({tag, "_addr"}, IMemAddr, exp_a);
    cur_pc = exp_a;
  endtask

  // Serve the outstanding request after lat wait cycles, then check the held instruction.
  task automatic serve(input string tag, input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) begin
      @(negedge Clk);
      chk({tag, "_addr_stable"}, IMemAddr, cur_pc);
    end
    IMemAck  = 1'b1;
    IMemData = data;
    data_q.push_back(data);
    @(negedge Clk);
    IMemAck  = 1'b0;
    IMemData = $urandom;
    chk({tag, "_valid"}, {63'd0, InstrValid}, 64'd1);
    chk({tag, "_instr"}, {32'd0, Instr}, {32'd0, data_q.pop_front()});
    chk({tag, "_instr_pc"}, InstrPC, cur_pc);
    chk({tag, "_req_low"}, {63'd0, IMemReq}, 64'd0);
  endtask

  task automatic consume(input string tag, input logic taken, input logic [63:0] imm,
                         input logic [63:0] exp_next);
    DecodeReady = 1'b1;
    BranchTaken = taken;
    BusImm      = imm;
    addr_q.push_back(exp_next);
    exp_count++;
    @(negedge Clk);
    DecodeReady = 1'b0;
    BranchTaken = 1'b0;
    BusImm      = {$urandom, $urandom};
    chk({tag, "_valid_low"}, {63'd0, InstrValid}, 64'd0);
    chk({tag, "_req_next"}, {63'd0, IMemReq}, 64'd1);
    chk({tag, "_count"}, {32'd0, InstrCount}, 64'(exp_count));
    wait_req(tag);
  endtask

  initial begin
    Resetl      = 1'b0;
    IMemAck     = 1'b0;
    IMemData    = 32'h0;
    DecodeReady = 1'b0;
    BranchTaken = 1'b0;
    BusImm      = 64'h0;
    cur_pc      = 64'h0;
    repeat (2) @(negedge Clk);
    chk("rst_req", {63'd0, IMemReq}, 64'd0);
    chk("rst_valid", {63'd0, InstrValid}, 64'd0);
    chk("rst_instr", {32'd0, Instr}, 64'd0);
    chk("rst_instr_pc", InstrPC, 64'd0);
    chk("rst_count", {32'd0, InstrCount}, 64'd0);
    chk("rst_addr", IMemAddr, RST_PC);

    Resetl = 1'b1;
    addr_q.push_back(64'h100);
    @(negedge Clk);
    chk("release_req", {63'd0, IMemReq}, 64'd1);
    wait_req("first");
    serve("first", 0, 32'h8B02_0020);

    consume("seq1", 1'b0, 64'h0, 64'h104);
    serve("seq1", 0, 32'h1111_0001);
    consume("seq2", 1'b0, 64'h0, 64'h108);
    serve("seq2", 1, 32'h1111_0002);
    consume("seq3", 1'b0, 64'h0, 64'h10C);
    chk("count3", {32'd0, InstrCount}, 64'd3);
    serve("seq3", 2, 32'hB400_0040);

    consume("back", 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h100);
    serve("b_instr", 0, 32'h1400_0013);
    consume("b_fwd", 1'b1, 64'h13, 64'h14C);
    serve("to200", 0, 32'h1400_002D);
    consume("to200", 1'b1, 64'h2D, 64'h200);
    serve("cb", 0, 32'hB4FF_FFE0);
    consume("cb_neg1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1FC);
    serve("to_top", 0, 32'h17FF_FF80);
    consume("to_top", 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FFFC);
    serve("top", 0, 32'h8B1F_03E0);
    consume("wrap", 1'b0, 64'h0, 64'h0);
    serve("zero", 0, 32'hD503_201F);

    // stalled decode: ack and branch noise must not disturb the held instruction
    for (int i = 0; i < 5; i++) begin
      IMemAck     = 1'b1;
      BranchTaken = 1'b1;
      IMemData    = $urandom;
      @(negedge Clk);
      chk("bp_instr", {32'd0, Instr}, 64'hD503_201F);
      chk("bp_instr_pc", InstrPC, 64'h0);
      chk("bp_req", {63'd0, IMemReq}, 64'd0);
      chk("bp_valid", {63'd0, InstrValid}, 64'd1);
    end
    IMemAck     = 1'b0;
    BranchTaken = 1'b0;
    consume("after_bp", 1'b0, 64'h0, 64'h4);

    @(negedge Clk);
    chk("slow_addr_stable", IMemAddr, 64'h4);
    Resetl   = 1'b0;
    IMemAck  = 1'b1;
    IMemData = 32'hBAD0_0001;
    @(negedge Clk);
    chk("midrst_req", {63'd0, IMemReq}, 64'd0);
    chk("midrst_valid", {63'd0, InstrValid}, 64'd0);
    chk("midrst_addr", IMemAddr, RST_PC);
    chk("midrst_count", {32'd0, InstrCount}, 64'd0);
    chk("midrst_instr", {32'd0, Instr}, 64'd0);
    Resetl   = 1'b1;
    IMemData = 32'hBAD0_0002;
    @(negedge Clk);
    IMemAck = 1'b0;
    chk("late_ack_valid", {63'd0, InstrValid}, 64'd0);
    chk("restart_req", {63'd0, IMemReq}, 64'd1);
    exp_count = 0;
    addr_q.push_back(RST_PC);
    wait_req("restart");
    serve("restart", 0, 32'h9100_0421);
    consume("restart_seq", 1'b0, 64'h0, 64'h104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
